// File: rtl/pin_mux_pkg.sv
// ============================================================================
// Module      : pin_mux_pkg
// Description : Shared constants and state encoding for the pin-mux map registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pin_mux_pkg;

    localparam int          MAP_W           = 8;
    localparam logic [7:0]  MAP_UNMAPPED    = 8'hFF;

    localparam logic        WR_SEL_PHYSICAL = 1'b0;
    localparam logic        WR_SEL_LOGICAL  = 1'b1;

    localparam logic [0:0]  ST_IDLE         = 1'b0;
    localparam logic [0:0]  ST_CLEAR        = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pin_mux_map_bank.sv
// ============================================================================
// Module      : pin_mux_map_bank
// Description : One map table: shadow entries plus an active copy loaded on commit.
//               Shadow output port exists only with PIN_MUX_MAP_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pin_mux_map_bank
    import pin_mux_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_addr,
    input  logic [MAP_W-1:0]         wr_data,
    input  logic                     clr_en,
    input  logic [7:0]               clr_addr,
    input  logic                     commit,
`ifdef PIN_MUX_MAP_READBACK_EN
    output logic [DEPTH*MAP_W-1:0]   shadow_map,
`endif
    output logic [DEPTH*MAP_W-1:0]   active_map
);

    logic [DEPTH*MAP_W-1:0] r_shadow;
    logic [DEPTH*MAP_W-1:0] r_active;
    logic [DEPTH*MAP_W-1:0] w_shadow_next;

    // Commit loads the post-update shadow so a same-cycle write or clear is included.
    always_comb begin
        w_shadow_next = r_shadow;
        for (int i = 0; i < DEPTH; i++) begin
            if (clr_en && (clr_addr == 8'(i)))
                w_shadow_next[i*MAP_W +: MAP_W] = MAP_UNMAPPED;
            if (wr_en && (wr_addr == 8'(i)))
                w_shadow_next[i*MAP_W +: MAP_W] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= {DEPTH{MAP_UNMAPPED}};
            r_active <= {DEPTH{MAP_UNMAPPED}};
        end else begin
            r_shadow <= w_shadow_next;
            if (commit)
                r_active <= w_shadow_next;
        end
    end

    assign active_map = r_active;
`ifdef PIN_MUX_MAP_READBACK_EN
    assign shadow_map = r_shadow;
`endif

endmodule

`default_nettype wire

// File: rtl/pin_mux_map_regs.sv
// ============================================================================
// Module      : pin_mux_map_regs
// Description : Shadow/active pin-mux map registers with commit and clear sweep.
//               Optional readback ports via PIN_MUX_MAP_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pin_mux_map_regs
    import pin_mux_pkg::*;
#(
    parameter int IO_PHYSICAL = 50,
    parameter int IO_LOGICAL  = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic                         wr_sel,
    input  logic [7:0]                   wr_addr,
    input  logic [7:0]                   wr_data,
    output logic                         wr_err,
    input  logic                         commit,
    input  logic                         clear,
    output logic                         busy,
    output logic                         commit_done,
`ifdef PIN_MUX_MAP_READBACK_EN
    input  logic                         rd_en,
    input  logic                         rd_sel,
    input  logic [7:0]                   rd_addr,
    input  logic                         rd_shadow,
    output logic [7:0]                   rd_data,
    output logic                         rd_valid,
`endif
    output logic [IO_PHYSICAL*MAP_W-1:0] physical_map,
    output logic [IO_LOGICAL*MAP_W-1:0]  logical_map
);

    localparam int         c_sweep_len  = max_int(IO_PHYSICAL, IO_LOGICAL);
    localparam logic [7:0] c_sweep_last = 8'(c_sweep_len - 1);
    localparam logic [8:0] c_phys_depth = 9'(IO_PHYSICAL);
    localparam logic [8:0] c_log_depth  = 9'(IO_LOGICAL);

    logic [0:0] r_state;
    logic [0:0] w_state_next;
    logic [7:0] r_idx;
    logic [7:0] w_idx_next;
    logic       r_pending;
    logic       w_pending_next;
    logic       r_wr_err;
    logic       r_commit_done;

    logic       w_wr_phys;
    logic       w_wr_log;
    logic       w_wr_err;
    logic       w_clr_phys;
    logic       w_clr_log;
    logic       w_commit;
    logic       w_phys_legal;
    logic       w_log_legal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= 8'd0;
            r_pending     <= 1'b0;
            r_wr_err      <= 1'b0;
            r_commit_done <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_idx         <= w_idx_next;
            r_pending     <= w_pending_next;
            r_wr_err      <= w_wr_err;
            r_commit_done <= w_commit;
        end
    end

    // A clear arriving with commit defers the commit to the end of the sweep.
    always_comb begin
        w_state_next   = r_state;
        w_idx_next     = r_idx;
        w_pending_next = r_pending;
        case (r_state)
            ST_IDLE: begin
                if (clear) begin
                    w_state_next   = ST_CLEAR;
                    w_idx_next     = 8'd0;
                    w_pending_next = commit;
                end
            end
            ST_CLEAR: begin
                w_idx_next = r_idx + 8'd1;
                if (commit)
                    w_pending_next = 1'b1;
                if (r_idx == c_sweep_last) begin
                    w_state_next   = ST_IDLE;
                    w_idx_next     = 8'd0;
                    w_pending_next = 1'b0;
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_idx_next     = 8'd0;
                w_pending_next = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_wr_phys    = 1'b0;
        w_wr_log     = 1'b0;
        w_wr_err     = 1'b0;
        w_clr_phys   = 1'b0;
        w_clr_log    = 1'b0;
        w_commit     = 1'b0;
        w_phys_legal = ({1'b0, wr_addr} < c_phys_depth);
        w_log_legal  = ({1'b0, wr_addr} < c_log_depth);
        case (r_state)
            ST_IDLE: begin
                w_wr_phys = wr_en && (wr_sel == WR_SEL_PHYSICAL) && w_phys_legal;
                w_wr_log  = wr_en && (wr_sel == WR_SEL_LOGICAL)  && w_log_legal;
                w_wr_err  = wr_en && !(w_wr_phys || w_wr_log);
                w_commit  = commit && !clear;
            end
            ST_CLEAR: begin
                w_wr_err   = wr_en;
                w_clr_phys = ({1'b0, r_idx} < c_phys_depth);
                w_clr_log  = ({1'b0, r_idx} < c_log_depth);
                w_commit   = (r_idx == c_sweep_last) && (r_pending || commit);
            end
            default: ;
        endcase
    end

`ifdef PIN_MUX_MAP_READBACK_EN
    logic [IO_PHYSICAL*MAP_W-1:0] w_phys_shadow;
    logic [IO_LOGICAL*MAP_W-1:0]  w_log_shadow;
    logic [7:0]                   w_rd_value;
    logic [7:0]                   r_rd_data;
    logic                         r_rd_valid;
`endif

    pin_mux_map_bank #(.DEPTH(IO_PHYSICAL)) u_phys_bank (
        .clk        (clk),
        .rst        (reset),
        .wr_en      (w_wr_phys),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clr_en     (w_clr_phys),
        .clr_addr   (r_idx),
        .commit     (w_commit),
`ifdef PIN_MUX_MAP_READBACK_EN
        .shadow_map (w_phys_shadow),
`endif
        .active_map (physical_map)
    );

    pin_mux_map_bank #(.DEPTH(IO_LOGICAL)) u_log_bank (
        .clk        (clk),
        .rst        (reset),
        .wr_en      (w_wr_log),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clr_en     (w_clr_log),
        .clr_addr   (r_idx),
        .commit     (w_commit),
`ifdef PIN_MUX_MAP_READBACK_EN
        .shadow_map (w_log_shadow),
`endif
        .active_map (logical_map)
    );

`ifdef PIN_MUX_MAP_READBACK_EN
    // Out-of-range reads fall through to the unmapped value.
    always_comb begin
        w_rd_value = MAP_UNMAPPED;
        if (rd_sel == WR_SEL_PHYSICAL) begin
            for (int i = 0; i < IO_PHYSICAL; i++)
                if (rd_addr == 8'(i))
                    w_rd_value = rd_shadow ? w_phys_shadow[i*MAP_W +: MAP_W]
                                           : physical_map[i*MAP_W +: MAP_W];
        end else begin
            for (int i = 0; i < IO_LOGICAL; i++)
                if (rd_addr == 8'(i))
                    w_rd_value = rd_shadow ? w_log_shadow[i*MAP_W +: MAP_W]
                                           : logical_map[i*MAP_W +: MAP_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data  <= 8'd0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en)
                r_rd_data <= w_rd_value;
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
`endif

    assign wr_err      = r_wr_err;
    assign commit_done = r_commit_done;
    assign busy        = (r_state == ST_CLEAR) | r_pending;

endmodule

`default_nettype wire

// File: tb/tb_pin_mux_map_regs.sv
// ============================================================================
// Module      : tb_pin_mux_map_regs
// Description : Scoreboard bench for pin_mux_map_regs with a table-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pin_mux_map_regs;

    localparam int P = 50;
    localparam int L = 6;
    localparam int N = (P > L) ? P : L;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           wr_en = 1'b0;
    logic           wr_sel = 1'b0;
    logic [7:0]     wr_addr = 8'd0;
    logic [7:0]     wr_data = 8'd0;
    logic           commit = 1'b0;
    logic           clear = 1'b0;
    logic           wr_err;
    logic           busy;
    logic           commit_done;
    logic [P*8-1:0] physical_map;
    logic [L*8-1:0] logical_map;
`ifdef PIN_MUX_MAP_READBACK_EN
    logic           rd_en = 1'b0;
    logic           rd_sel = 1'b0;
    logic [7:0]     rd_addr = 8'd0;
    logic           rd_shadow = 1'b0;
    logic [7:0]     rd_data;
    logic           rd_valid;
`endif

    pin_mux_map_regs #(.IO_PHYSICAL(P), .IO_LOGICAL(L)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_err       (wr_err),
        .commit       (commit),
        .clear        (clear),
        .busy         (busy),
        .commit_done  (commit_done),
`ifdef PIN_MUX_MAP_READBACK_EN
        .rd_en        (rd_en),
        .rd_sel       (rd_sel),
        .rd_addr      (rd_addr),
        .rd_shadow    (rd_shadow),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
`endif
        .physical_map (physical_map),
        .logical_map  (logical_map)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           busy;
        logic           wr_err;
        logic           cd;
        logic [P*8-1:0] pm;
        logic [L*8-1:0] lm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: plain tables plus a countdown for the sweep.
    logic [7:0] sp[P];
    logic [7:0] sl[L];
    logic [7:0] ap[P];
    logic [7:0] al[L];
    bit         m_clearing = 0;
    int         m_swept = 0;
    bit         m_pend = 0;

    task automatic check(input string name, input logic [P*8-1:0] act, input logic [P*8-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("busy",         {{(P*8-1){1'b0}}, busy},        {{(P*8-1){1'b0}}, e.busy});
                check("wr_err",       {{(P*8-1){1'b0}}, wr_err},      {{(P*8-1){1'b0}}, e.wr_err});
                check("commit_done",  {{(P*8-1){1'b0}}, commit_done}, {{(P*8-1){1'b0}}, e.cd});
                check("physical_map", physical_map, e.pm);
                check("logical_map",  {{((P-L)*8){1'b0}}, logical_map}, {{((P-L)*8){1'b0}}, e.lm});
            end
        end
    end

    task automatic model_commit();
        for (int i = 0; i < P; i++) ap[i] = sp[i];
        for (int i = 0; i < L; i++) al[i] = sl[i];
    endtask

    task automatic step(input bit r, input bit we, input bit sel, input int addr,
                        input int data, input bit cm, input bit cl);
        exp_t e;
        bit   err;
        bit   cd;
        @(negedge clk);
        reset   = r;
        wr_en   = we;
        wr_sel  = sel;
        wr_addr = 8'(addr);
        wr_data = 8'(data);
        commit  = cm;
        clear   = cl;
        err = 0;
        cd  = 0;
        if (r) begin
            for (int i = 0; i < P; i++) begin sp[i] = 8'hFF; ap[i] = 8'hFF; end
            for (int i = 0; i < L; i++) begin sl[i] = 8'hFF; al[i] = 8'hFF; end
            m_clearing = 0;
            m_swept    = 0;
            m_pend     = 0;
        end else if (!m_clearing) begin
            err = we && (addr >= (sel ? L : P));
            if (we && !err) begin
                if (sel) sl[addr] = 8'(data);
                else     sp[addr] = 8'(data);
            end
            if (cl) begin
                m_clearing = 1;
                m_swept    = 0;
                m_pend     = cm;
            end else if (cm) begin
                model_commit();
                cd = 1;
            end
        end else begin
            err = we;
            if (cm) m_pend = 1;
            if (m_swept < P) sp[m_swept] = 8'hFF;
            if (m_swept < L) sl[m_swept] = 8'hFF;
            m_swept++;
            if (m_swept == N) begin
                m_clearing = 0;
                if (m_pend) begin
                    model_commit();
                    cd = 1;
                end
                m_pend = 0;
            end
        end
        e.busy   = m_clearing | m_pend;
        e.wr_err = err;
        e.cd     = cd;
        for (int i = 0; i < P; i++) e.pm[i*8 +: 8] = ap[i];
        for (int i = 0; i < L; i++) e.lm[i*8 +: 8] = al[i];
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int rv;
        bit sel;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Write then commit
        step(0, 1, 0, 3, 8'h02, 0, 0);
        step(0, 1, 1, 2, 8'h03, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(1);

        // Out-of-range writes, then commit to show shadow unchanged
        step(0, 1, 0, 50, 8'h11, 0, 0);
        step(0, 1, 1, 6, 8'h22, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);

        // Same-cycle write + commit
        step(0, 1, 0, 0, 8'h05, 1, 0);
        idle(1);

        // Clear with deferred commit and a rejected write mid-sweep
        step(0, 1, 0, 10, 8'h01, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        for (int c = 0; c < N; c++)
            step(0, c == 5, 0, 7, 8'h44, c == 20, c == 12);
        idle(2);

        // Reset mid-sweep with a pending commit
        step(0, 1, 1, 1, 8'h09, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        for (int c = 0; c < 30; c++) step(0, 0, 0, 0, 0, c == 10, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Commit held high
        step(0, 1, 0, 49, 8'h31, 1, 0);
        step(0, 1, 1, 5, 8'h32, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(1);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            rv  = int'($urandom_range(0, 999));
            sel = 1'($urandom_range(0, 1));
            step(rv < 3, $urandom_range(0, 2) != 0, sel,
                 sel ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 60)),
                 int'($urandom_range(0, 255)),
                 $urandom_range(0, 6) == 0, rv >= 990);
        end
        idle(N + 2);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d queued expectations, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pin_mux_map_regs.md
Name: pin_mux_map_regs

Overview:
- Configuration stage directly upstream of the pin multiplexer. Holds the per-pin map bytes it consumes:
  - physical_map: logical index per physical pin.
  - logical_map: physical index per logical pin.
- Writes land in shadow registers; a commit copies shadow to active in one cycle, so the mux never sees a half-updated map.
- Includes a sequential clear engine that sweeps all shadow entries to "unmapped" (0xFF).

Parameters:
- IO_PHYSICAL, 50, number of physical pins (1..255).
- IO_LOGICAL, 6, number of logical pins (1..255).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- wr_en  input  1  shadow write strobe
- wr_sel  input  1  0 = physical table, 1 = logical table
- wr_addr  input  8  entry index within the selected table
- wr_data  input  8  map byte to store
- wr_err  output  1  one-cycle pulse: write rejected
- commit  input  1  shadow to active request (level sampled each cycle)
- clear  input  1  start a shadow sweep to 0xFF
- busy  output  1  high while clearing or a commit is pending
- commit_done  output  1  one-cycle pulse the cycle active maps change
- physical_map  output  IO_PHYSICAL*8  active physical table, entry i at [i*8+:8]
- logical_map  output  IO_LOGICAL*8  active logical table, entry i at [i*8+:8]

Behaviour:
- Clock and reset: single clock clk. reset is synchronous, active-high.
- On reset:
  - All shadow and active entries = 0xFF.
  - State = IDLE, sweep index = 0, pending = 0.
  - wr_err, busy, commit_done = 0.
- States are IDLE, CLEAR.
- Write in IDLE:
  - Legal when wr_addr < IO_PHYSICAL (wr_sel=0) or wr_addr < IO_LOGICAL (wr_sel=1).
  - A legal write updates the shadow entry at the next edge.
  - An out-of-range write leaves shadow unchanged and pulses wr_err the next cycle.
- wr_data is stored unchecked. Values >= the opposite table size are legal and mean unmapped downstream.
- Commit in IDLE (commit=1, clear=0):
  - At the next edge, active <= shadow including any same-cycle legal write. Latency 1.
  - commit_done pulses in that same cycle.
- clear in IDLE:
  - Move to CLEAR with index = 0; busy = 1 from the next cycle.
  - Each CLEAR cycle writes 0xFF to physical shadow[index] if index < IO_PHYSICAL, and to logical shadow[index] if index < IO_LOGICAL, then index++.
  - Leave CLEAR after index = max(IO_PHYSICAL, IO_LOGICAL)-1.
  - The sweep takes exactly max(IO_PHYSICAL, IO_LOGICAL) cycles. Active maps are untouched.
- Simultaneous clear+commit in IDLE: clear wins and commit is recorded as pending.
- Any wr_en during CLEAR is rejected with a wr_err pulse.
- commit during CLEAR sets pending. On the final sweep cycle with pending set, active <= fully cleared shadow at the same edge that returns to IDLE. commit_done pulses and pending clears.
- busy = (state == CLEAR) | pending.
- clear asserted during CLEAR is ignored; the sweep does not restart.
- reset mid-sweep or mid-pending returns everything to reset values; no commit occurs.
- commit held high in IDLE commits every cycle; each commit pulses commit_done.

Optional Feature:
- Macro: PIN_MUX_MAP_READBACK_EN.
- With the macro defined, add these ports:
  - rd_en  input  1
  - rd_sel  input  1
  - rd_addr  input  8
  - rd_shadow  input  1 (0 = active, 1 = shadow)
  - rd_data  output  8
  - rd_valid  output  1
- Readback timing: registered, latency 1. rd_valid pulses one cycle after rd_en.
- Readback values:
  - Out-of-range address returns 0xFF with rd_valid still asserted.
  - Shadow reads during CLEAR return the current (partially swept) contents.
  - rd_data and rd_valid reset to 0.
- Without the macro: no read ports and no read logic.

Decomposition:
- Shared package pin_mux_pkg:
  - MAP_W = 8
  - MAP_UNMAPPED = 8'hFF
  - WR_SEL_PHYSICAL = 1'b0, WR_SEL_LOGICAL = 1'b1
  - State encoding localparams (IDLE, CLEAR)
- One natural sub-module: pin_mux_map_bank (parameter DEPTH). It holds one table's shadow and active arrays and provides write, clear-entry and commit ports. It is instantiated twice (physical, logical); the top keeps the FSM and error logic.

Test Plan:
- Reset: assert reset 2 cycles → all 50 physical_map bytes and 6 logical_map bytes = 0xFF, busy = 0.
- Write then commit: write phys[3] = 0x02 and log[2] = 0x03, then commit → one cycle later physical_map[31:24] = 0x02, logical_map[23:16] = 0x03, commit_done pulses once. Before the commit, both active tables remain 0xFF.
- Write errors: write wr_sel=0 addr 50, and wr_sel=1 addr 6 → wr_err pulses each time, shadow unchanged (confirmed by a commit showing 0xFF).
- Same-cycle write+commit: wr_en (phys[0] = 0x05) with commit in the same cycle → physical_map[7:0] = 0x05 the next cycle.
- Clear with deferred commit: program phys[10] = 0x01 and commit; then clear; then commit at sweep cycle 20 → busy stays high 50 cycles. physical_map[87:80] stays 0x01 until the final sweep edge, then becomes 0xFF with a single commit_done. A write at sweep cycle 5 gives wr_err.
- Reset mid-sweep: reset at sweep cycle 30 with commit pending → busy = 0 and all maps 0xFF, with no commit_done pulse.
